// File: rtl/screen_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : screen_wr_sched
// Purpose  : Screen RAM write-port scheduler. Shares the single RAM write
//            port between buffered host register writes (small synchronous
//            FIFO) and a block-fill engine (clear screen / rectangle fill).
//            At most one RAM write is issued per clock. When both sides have
//            work, a round-robin arbiter alternates grants (host wins the
//            first tie after reset).
// Ports    : clk, rst_n (async, active-low)
//            host_req/host_addr/host_data -> FIFO push, host_ready = !full
//            fifo_level                   -> current FIFO occupancy
//            fill_start/base/count/value  -> fill command, sampled when idle
//            fill_busy, fill_done         -> fill status / completion pulse
//            ram_wren/ram_wraddress/ram_data -> registered RAM write port
// Config   : SCREEN_WR_FILL_EN - when defined, the fill engine and the
//            round-robin arbiter are built. When undefined, the fill inputs
//            are ignored, fill_busy/fill_done read 0 and the FIFO drains at
//            one write per clock.
// Revision : 1.0 - initial release
// ============================================================================
module screen_wr_sched #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          host_req,
  input  logic [ADDR_W-1:0]             host_addr,
  input  logic [DATA_W-1:0]             host_data,
  output logic                          host_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          fill_start,
  input  logic [ADDR_W-1:0]             fill_base,
  input  logic [ADDR_W-1:0]             fill_count,
  input  logic [DATA_W-1:0]             fill_value,
  output logic                          fill_busy,
  output logic                          fill_done,
  output logic                          ram_wren,
  output logic [ADDR_W-1:0]             ram_wraddress,
  output logic [DATA_W-1:0]             ram_data
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_lvl_w = c_ptr_w + 1;
  localparam int c_ent_w = ADDR_W + DATA_W;
  localparam logic [c_lvl_w-1:0] c_full_lvl = c_lvl_w'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOST = 2'b01,
    ST_FILL = 2'b10
  } arb_state_t;

  // --------------------------------------------------------------------------
  // Host write FIFO
  // --------------------------------------------------------------------------
  logic [c_ent_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_lvl_w-1:0] r_level;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [c_ent_w-1:0] w_head;

  assign w_full     = (r_level == c_full_lvl);
  assign w_empty    = (r_level == '0);
  // Readiness comes from registered state only; a same-cycle pop does not
  // make room for a push.
  assign w_push     = host_req & ~w_full;
  assign w_head     = r_mem[r_rd_ptr];
  assign host_ready = ~w_full;
  assign fifo_level = r_level;

  // Storage needs no reset: occupancy is tracked by r_level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {host_addr, host_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_lvl_w'(1);
        2'b01:   r_level <= r_level - c_lvl_w'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration decision (combinational, from registered state only)
  // --------------------------------------------------------------------------
  arb_state_t r_state;
  arb_state_t w_next;
  logic       w_host_pend;

  assign w_host_pend = ~w_empty;
  assign w_pop       = (w_next == ST_HOST);

`ifdef SCREEN_WR_FILL_EN
  // --------------------------------------------------------------------------
  // Fill engine
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] r_cursor;
  logic [ADDR_W-1:0] r_remain;
  logic [DATA_W-1:0] r_value;
  logic              r_fill_busy;
  logic              r_fill_done;
  logic              r_last_fill;   // 1: the most recent grant went to the fill
  logic              w_fill_pend;
  logic              w_grant_fill;

  assign w_fill_pend  = r_fill_busy;
  assign w_grant_fill = (w_next == ST_FILL);
  assign fill_busy    = r_fill_busy;
  assign fill_done    = r_fill_done;

  always_comb begin
    w_next = ST_IDLE;
    if (w_host_pend && w_fill_pend) begin
      // Tie: the side not served last wins, giving strict H,F,H,F alternation.
      w_next = r_last_fill ? ST_HOST : ST_FILL;
    end else if (w_host_pend) begin
      w_next = ST_HOST;
    end else if (w_fill_pend) begin
      w_next = ST_FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cursor    <= '0;
      r_remain    <= '0;
      r_value     <= '0;
      r_fill_busy <= 1'b0;
      r_fill_done <= 1'b0;
    end else begin
      r_fill_done <= 1'b0;
      if (!r_fill_busy) begin
        if (fill_start) begin
          r_cursor <= fill_base;
          r_remain <= fill_count;
          r_value  <= fill_value;
          // A zero-length fill completes immediately without ever going busy.
          if (fill_count == '0) begin
            r_fill_done <= 1'b1;
          end else begin
            r_fill_busy <= 1'b1;
          end
        end
      end else if (w_grant_fill) begin
        // Cursor wraps naturally modulo 2^ADDR_W.
        r_cursor <= r_cursor + ADDR_W'(1);
        r_remain <= r_remain - ADDR_W'(1);
        if (r_remain == ADDR_W'(1)) begin
          r_fill_busy <= 1'b0;
          r_fill_done <= 1'b1;
        end
      end
    end
  end
`else
  logic w_fill_unused;

  assign w_fill_unused = ^{fill_start, fill_base, fill_count, fill_value};
  assign fill_busy     = 1'b0;
  assign fill_done     = 1'b0;

  always_comb begin
    w_next = ST_IDLE;
    if (w_host_pend) begin
      w_next = ST_HOST;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Arbiter FSM and registered RAM write port
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ram_addr <= '0;
      r_ram_data <= '0;
`ifdef SCREEN_WR_FILL_EN
      r_last_fill <= 1'b1;
`endif
    end else begin
      r_state <= w_next;
      // Address and data hold their last values on idle cycles.
      if (w_next == ST_HOST) begin
        r_ram_addr <= w_head[c_ent_w-1:DATA_W];
        r_ram_data <= w_head[DATA_W-1:0];
      end
`ifdef SCREEN_WR_FILL_EN
      else if (w_next == ST_FILL) begin
        r_ram_addr <= r_cursor;
        r_ram_data <= r_value;
      end
      if (w_next != ST_IDLE) begin
        r_last_fill <= (w_next == ST_FILL);
      end
`endif
    end
  end

  // The state register is the record of this cycle's write, so the enable
  // decodes straight from it.
  assign ram_wren      = (r_state != ST_IDLE);
  assign ram_wraddress = r_ram_addr;
  assign ram_data      = r_ram_data;

endmodule
`default_nettype wire

// File: tb/tb_screen_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_screen_wr_sched
// Purpose  : Directed self-checking bench for screen_wr_sched. Expectations
//            follow the SCREEN_WR_FILL_EN build option of the compile.
// Revision : 1.0 - initial release
// ============================================================================
module tb_screen_wr_sched;

`ifdef SCREEN_WR_FILL_EN
  localparam bit FILL_ON = 1'b1;
`else
  localparam bit FILL_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        host_req;
  logic [15:0] host_addr;
  logic [7:0]  host_data;
  logic        host_ready;
  logic [2:0]  fifo_level;
  logic        fill_start;
  logic [15:0] fill_base;
  logic [15:0] fill_count;
  logic [7:0]  fill_value;
  logic        fill_busy;
  logic        fill_done;
  logic        ram_wren;
  logic [15:0] ram_wraddress;
  logic [7:0]  ram_data;

  int n_total = 0;
  int n_bad   = 0;

  screen_wr_sched #(
    .ADDR_W     (16),
    .DATA_W     (8),
    .FIFO_DEPTH (4)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host_req      (host_req),
    .host_addr     (host_addr),
    .host_data     (host_data),
    .host_ready    (host_ready),
    .fifo_level    (fifo_level),
    .fill_start    (fill_start),
    .fill_base     (fill_base),
    .fill_count    (fill_count),
    .fill_value    (fill_value),
    .fill_busy     (fill_busy),
    .fill_done     (fill_done),
    .ram_wren      (ram_wren),
    .ram_wraddress (ram_wraddress),
    .ram_data      (ram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every RAM write as {addr, data}, plus fill_done pulses.
  logic [23:0] wq[$];
  int          n_done  = 0;
  int          done_at = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_wren) wq.push_back({ram_wraddress, ram_data});
      if (fill_done) begin
        n_done  <= n_done + 1;
        done_at <= wq.size();
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one cycle, then check the write port and fill status.
  task automatic step_chk(input string tag, input logic ew, input logic [15:0] ea,
                          input logic [7:0] ed, input logic eb, input logic edn);
    @(negedge clk);
    chk({tag, "_wren"}, 32'(ram_wren), 32'(ew));
    if (ew) begin
      chk({tag, "_addr"}, 32'(ram_wraddress), 32'(ea));
      chk({tag, "_data"}, 32'(ram_data), 32'(ed));
    end
    chk({tag, "_busy"}, 32'(fill_busy), 32'(eb));
    chk({tag, "_done"}, 32'(fill_done), 32'(edn));
  endtask

  task automatic start_fill(input logic [15:0] b, input logic [15:0] c, input logic [7:0] v);
    fill_start = 1'b1;
    fill_base  = b;
    fill_count = c;
    fill_value = v;
    @(negedge clk);
    fill_start = 1'b0;
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] d);
    int n;
    n = 0;
    host_req  = 1'b1;
    host_addr = a;
    host_data = d;
    while (!host_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("push_wait", 32'(n < 20), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] exp_q[$];
    int          k;
    int          nh;
    int          nf;
    int          sz;
    logic        rdy;
    logic        saw_full;

    rst_n      = 1'b0;
    host_req   = 1'b0;
    host_addr  = '0;
    host_data  = '0;
    fill_start = 1'b0;
    fill_base  = '0;
    fill_count = '0;
    fill_value = '0;

    // ---------------- reset values ----------------
    repeat (3) @(negedge clk);
    chk("rst_wren",  32'(ram_wren), 32'd0);
    chk("rst_addr",  32'(ram_wraddress), 32'd0);
    chk("rst_data",  32'(ram_data), 32'd0);
    chk("rst_busy",  32'(fill_busy), 32'd0);
    chk("rst_done",  32'(fill_done), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ready", 32'(host_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- single host write ----------------
    host_req  = 1'b1;
    host_addr = 16'h1234;
    host_data = 8'hA5;
    @(negedge clk);
    host_req = 1'b0;
    chk("t1_level1", 32'(fifo_level), 32'd1);
    chk("t1_nowr",   32'(ram_wren), 32'd0);
    step_chk("t1_wr", 1'b1, 16'h1234, 8'hA5, 1'b0, 1'b0);
    chk("t1_level0", 32'(fifo_level), 32'd0);
    step_chk("t1_idle", 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    chk("t1_hold", 32'(ram_wraddress), 32'h1234);

    // ---------------- fill 0x0010 x3 ----------------
    start_fill(16'h0010, 16'd3, 8'h20);
    chk("f3_busy", 32'(fill_busy), 32'(FILL_ON));
    chk("f3_nowr", 32'(ram_wren), 32'd0);
    step_chk("f3_a", FILL_ON, 16'h0010, 8'h20, FILL_ON, 1'b0);
    step_chk("f3_b", FILL_ON, 16'h0011, 8'h20, FILL_ON, 1'b0);
    step_chk("f3_c", FILL_ON, 16'h0012, 8'h20, 1'b0, FILL_ON);
    step_chk("f3_end", 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);

    // ---------------- fill wrap 0xFFFE x4 ----------------
    start_fill(16'hFFFE, 16'd4, 8'h5A);
    step_chk("fw_a", FILL_ON, 16'hFFFE, 8'h5A, FILL_ON, 1'b0);
    step_chk("fw_b", FILL_ON, 16'hFFFF, 8'h5A, FILL_ON, 1'b0);
    step_chk("fw_c", FILL_ON, 16'h0000, 8'h5A, FILL_ON, 1'b0);
    step_chk("fw_d", FILL_ON, 16'h0001, 8'h5A, 1'b0, FILL_ON);
    step_chk("fw_end", 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);

    // ---------------- five host writes during a fill ----------------
    wq.delete();
    n_done = 0;
    start_fill(16'h3000, 16'd20, 8'h11);
    @(negedge clk);
    for (int i = 0; i < 5; i++) push(16'(16'h4000 + i), 8'(8'hB0 + i));
    host_req = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    nh = 0;
    nf = 0;
    foreach (wq[i]) begin
      if (wq[i][23:20] == 4'h4) begin
        chk("t2_host", 32'(wq[i]), 32'({16'(16'h4000 + nh), 8'(8'hB0 + nh)}));
        nh++;
      end else begin
        chk("t2_fill", 32'(wq[i]), 32'({16'(16'h3000 + nf), 8'h11}));
        nf++;
      end
    end
    chk("t2_nhost", 32'(nh), 32'd5);
    chk("t2_nfill", 32'(nf), FILL_ON ? 32'd20 : 32'd0);
    chk("t2_ndone", 32'(n_done), 32'(FILL_ON));

    // ---------------- contention: fill x8 vs continuous host ----------------
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wq.delete();
    n_done   = 0;
    done_at  = 0;
    saw_full = 1'b0;
    k        = 0;
    fill_start = 1'b1;
    fill_base  = 16'h0100;
    fill_count = 16'd8;
    fill_value = 8'h77;
    host_req   = 1'b1;
    host_addr  = 16'h2000;
    host_data  = 8'h00;
    for (int c = 0; c < 30; c++) begin
      rdy = host_ready;
      @(negedge clk);
      fill_start = 1'b0;
      if (fifo_level == 3'd4 && !saw_full) begin
        saw_full = 1'b1;
        chk("cont_full_ready", 32'(host_ready), 32'd0);
      end
      if (rdy) begin
        k++;
        host_addr = 16'(16'h2000 + k);
        host_data = 8'(k);
      end
    end
    host_req = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    exp_q.delete();
    for (int i = 0; i < k; i++) begin
      exp_q.push_back({16'(16'h2000 + i), 8'(i)});
      if (FILL_ON && i < 8) exp_q.push_back({16'(16'h0100 + i), 8'h77});
    end
    chk("cont_size", 32'(wq.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < wq.size()) chk("cont_stream", 32'(wq[i]), 32'(exp_q[i]));
    end
    chk("cont_saw_full", 32'(saw_full), 32'(FILL_ON));
    chk("cont_ndone", 32'(n_done), 32'(FILL_ON));
    chk("cont_done_at", 32'(done_at), FILL_ON ? 32'd16 : 32'd0);

    // ---------------- reset mid-fill ----------------
    wq.delete();
    n_done = 0;
    start_fill(16'h6000, 16'd100, 8'h33);
    repeat (40) @(negedge clk);
    #1;
    chk("mid_written", 32'(wq.size()), FILL_ON ? 32'd40 : 32'd0);
    host_req  = 1'b1;
    host_addr = 16'h7000;
    host_data = 8'hEE;
    repeat (3) @(negedge clk);
    host_req = 1'b0;
    chk("mid_level_nz", 32'(fifo_level != 3'd0), 32'd1);
    chk("mid_busy", 32'(fill_busy), 32'(FILL_ON));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_wren",  32'(ram_wren), 32'd0);
    chk("ar_addr",  32'(ram_wraddress), 32'd0);
    chk("ar_data",  32'(ram_data), 32'd0);
    chk("ar_busy",  32'(fill_busy), 32'd0);
    chk("ar_done",  32'(fill_done), 32'd0);
    chk("ar_level", 32'(fifo_level), 32'd0);
    chk("ar_ready", 32'(host_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    sz = wq.size();
    repeat (6) @(negedge clk);
    #1;
    chk("post_rst_nowr", 32'(wq.size()), 32'(sz));
    chk("post_rst_ndone", 32'(n_done), 32'd0);
    chk("post_rst_busy", 32'(fill_busy), 32'd0);

    // ---------------- zero-length fill ----------------
    start_fill(16'h0777, 16'd0, 8'h99);
    chk("z_done", 32'(fill_done), 32'(FILL_ON));
    chk("z_busy", 32'(fill_busy), 32'd0);
    chk("z_nowr", 32'(ram_wren), 32'd0);
    step_chk("z_after", 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("z_nowr_total", 32'(wq.size()), 32'(sz));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
